// File: rtl/crc_check.sv
// Serial CRC checker: divides a {data, crc} codeword by g(x)=x^5+x^4+x^2+1, one bit per clock.
// Define CRC_CORRECT_EN to add single-bit error correction and the 'corrected' output.
module crc_check #(
  parameter int DATA_W = 10,
  parameter int CRC_W  = 5,
  parameter logic [CRC_W-1:0] POLY = 5'h15,
  parameter int CNT_W  = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W+CRC_W-1:0]  codeword_in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        data_out,
  output logic [CRC_W-1:0]         syndrome,
  output logic                     crc_ok,
  output logic [CNT_W-1:0]         err_cnt,
  input  logic                     cnt_clr,
  output logic                     busy
`ifdef CRC_CORRECT_EN
  ,
  output logic                     corrected
`endif
);

  localparam int CW = DATA_W + CRC_W;
  localparam int BW = $clog2(CW);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t            state;
  logic [CW-1:0]     sh_reg;
  logic [CRC_W-1:0]  rem;
  logic [BW-1:0]     bit_cnt;
  logic [CRC_W:0]    t;
  logic [CRC_W-1:0]  next_rem;
  logic              last_step;
  logic [DATA_W-1:0] done_data;

  // One long-division step: shift the next codeword bit into the remainder.
  always_comb begin
    t         = {rem, sh_reg[bit_cnt]};
    next_rem  = t[CRC_W] ? (t[CRC_W-1:0] ^ POLY) : t[CRC_W-1:0];
    last_step = (state == SHIFT) && (bit_cnt == '0);
  end

`ifdef CRC_CORRECT_EN
  logic             fix_hit;
  logic [CRC_W-1:0] pw;

  // Walk x^k mod g for every codeword position; a match pinpoints the flipped bit.
  always_comb begin
    done_data = sh_reg[CW-1:CRC_W];
    fix_hit   = 1'b0;
    pw        = CRC_W'(1);
    for (int k = 0; k < CRC_W; k++) begin
      if (next_rem == pw) fix_hit = 1'b1;
      pw = pw[CRC_W-1] ? ((pw << 1) ^ POLY) : (pw << 1);
    end
    for (int k = CRC_W; k < CW; k++) begin
      if (next_rem == pw) begin
        fix_hit              = 1'b1;
        done_data[k-CRC_W]   = ~done_data[k-CRC_W];
      end
      pw = pw[CRC_W-1] ? ((pw << 1) ^ POLY) : (pw << 1);
    end
  end
`else
  always_comb begin
    done_data = sh_reg[CW-1:CRC_W];
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      sh_reg    <= '0;
      rem       <= '0;
      bit_cnt   <= '0;
      out_valid <= 1'b0;
      data_out  <= '0;
      syndrome  <= '0;
      crc_ok    <= 1'b0;
      err_cnt   <= '0;
`ifdef CRC_CORRECT_EN
      corrected <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sh_reg  <= codeword_in;
            rem     <= '0;
            bit_cnt <= BW'(CW - 1);
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          rem <= next_rem;
          if (bit_cnt == '0) begin
            state     <= DONE;
            syndrome  <= next_rem;
            crc_ok    <= (next_rem == '0);
            data_out  <= done_data;
            out_valid <= 1'b1;
`ifdef CRC_CORRECT_EN
            corrected <= fix_hit;
`endif
          end else begin
            bit_cnt <= bit_cnt - 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      // Clear wins over a simultaneous error increment.
      if (cnt_clr)
        err_cnt <= '0;
      else if (last_step && (next_rem != '0) && (err_cnt != '1))
        err_cnt <= err_cnt + 1'b1;
    end
  end

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);

endmodule
